// File: rtl/rc_pulse_decoder_pkg.sv
// Shared command encodings and decoder states for the RC pulse decoder and
// the steering/throttle PWM generator, so both ends agree on the code values.
package rc_pulse_decoder_pkg;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2
  } rc_state_e;

  localparam logic [1:0] CODE_NEUTRAL = 2'b00;
  localparam logic [1:0] CODE_LOW     = 2'b01;
  localparam logic [1:0] CODE_HIGH    = 2'b10;

  localparam int WIDTH_BITS = 12;

  localparam int DEF_TICKS_PER_US = 50;
  localparam int DEF_MIN_US       = 900;
  localparam int DEF_MAX_US       = 2100;
  localparam int DEF_CENTER_LO_US = 1400;
  localparam int DEF_CENTER_HI_US = 1600;
  localparam int DEF_TIMEOUT_US   = 25000;

  // Widths inside the centre band (bounds included) are neutral.
  function automatic logic [1:0] decode_width(input logic [WIDTH_BITS-1:0] width,
                                              input logic [WIDTH_BITS-1:0] lo,
                                              input logic [WIDTH_BITS-1:0] hi);
    logic [1:0] result;
    result = CODE_NEUTRAL;
    if (width < lo) begin
      result = CODE_LOW;
    end else if (width > hi) begin
      result = CODE_HIGH;
    end
    return result;
  endfunction

endpackage

// File: rtl/rc_pulse_decoder_sync_edge.sv
// Two-flop synchronizer plus a history flop giving rise/fall strobes.
// primed_o goes high once s2 holds a genuine sample of the pin after reset.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic primed_o
);

  logic       s1_q;
  logic       s2_q;
  logic       s3_q;
  logic [1:0] fill_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      fill_q <= 2'd0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
      if (fill_q != 2'd2) begin
        fill_q <= fill_q + 2'd1;
      end
    end
  end

  assign level_o  = s2_q;
  assign rise_o   = s2_q & ~s3_q;
  assign fall_o   = ~s2_q & s3_q;
  assign primed_o = (fill_q == 2'd2);

endmodule

// File: rtl/rc_pulse_decoder.sv
// Measures the high time of an RC servo pulse in microseconds and turns each
// accepted pulse into a 2-bit command code, with a loss-of-signal fail-safe.
module rc_pulse_decoder
  import rc_pulse_decoder_pkg::*;
#(
  parameter int TICKS_PER_US = DEF_TICKS_PER_US,
  parameter int MIN_US       = DEF_MIN_US,
  parameter int MAX_US       = DEF_MAX_US,
  parameter int CENTER_LO_US = DEF_CENTER_LO_US,
  parameter int CENTER_HI_US = DEF_CENTER_HI_US,
  parameter int TIMEOUT_US   = DEF_TIMEOUT_US
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pulse_in,
  output logic [WIDTH_BITS-1:0] width_us,
  output logic [1:0]            code,
  output logic                  pulse_valid,
  output logic                  pulse_err,
  output logic                  signal_lost
);

  localparam int PRESC_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam int LOST_W  = $clog2(TIMEOUT_US + 1);

  localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(TICKS_PER_US - 1);
  localparam logic [LOST_W-1:0]     LOST_LIMIT = LOST_W'(TIMEOUT_US);
  localparam logic [WIDTH_BITS-1:0] MIN_W      = WIDTH_BITS'(MIN_US);
  localparam logic [WIDTH_BITS-1:0] MAX_W      = WIDTH_BITS'(MAX_US);
  localparam logic [WIDTH_BITS-1:0] CLO_W      = WIDTH_BITS'(CENTER_LO_US);
  localparam logic [WIDTH_BITS-1:0] CHI_W      = WIDTH_BITS'(CENTER_HI_US);

  logic line;
  logic rise;
  logic fall;
  logic primed;

  rc_state_e             state_q,     state_d;
  logic [PRESC_W-1:0]    presc_q,     presc_d;
  logic [WIDTH_BITS-1:0] width_cnt_q, width_cnt_d;
  logic [LOST_W-1:0]     lost_cnt_q,  lost_cnt_d;
  logic [WIDTH_BITS-1:0] width_q,     width_d;
  logic [1:0]            code_q,      code_d;
  logic                  valid_q,     valid_d;
  logic                  err_q,       err_d;
  logic                  lost_q,      lost_d;

  logic us_tick;
  logic in_range;
  logic accept;
  logic reject;
  logic overrun;

  sync_edge u_sync (
    .clk      (clk),
    .rst      (rst),
    .d_i      (pulse_in),
    .level_o  (line),
    .rise_o   (rise),
    .fall_o   (fall),
    .primed_o (primed)
  );

  assign us_tick  = (presc_q == PRESC_LAST);
  assign in_range = (width_cnt_q >= MIN_W) && (width_cnt_q <= MAX_W);
  assign accept   = (state_q == HIGH) && fall && in_range;
  assign reject   = (state_q == HIGH) && fall && !in_range;
  // A tick at MAX would push the count past the longest legal pulse.
  assign overrun  = (state_q == HIGH) && !fall && us_tick && (width_cnt_q >= MAX_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARM:     if (primed && !line) state_d = IDLE;
      IDLE:    if (rise) state_d = HIGH;
      HIGH: begin
        if (fall) begin
          state_d = IDLE;
        end else if (overrun) begin
          state_d = ARM;
        end
      end
      default: state_d = ARM;
    endcase
  end

  always_comb begin
    presc_d     = (rise || us_tick) ? '0 : presc_q + PRESC_W'(1);
    width_cnt_d = width_cnt_q;
    lost_cnt_d  = lost_cnt_q;
    width_d     = width_q;
    code_d      = code_q;
    lost_d      = lost_q;
    valid_d     = accept;
    err_d       = reject | overrun;

    if (state_q == IDLE && rise) begin
      width_cnt_d = '0;
    end else if (state_q == HIGH && us_tick && !overrun) begin
      width_cnt_d = width_cnt_q + WIDTH_BITS'(1);
    end

    if (accept) begin
      lost_cnt_d = '0;
    end else if (us_tick && lost_cnt_q != LOST_LIMIT) begin
      lost_cnt_d = lost_cnt_q + LOST_W'(1);
    end

    // An accepted pulse takes priority over a timeout expiring the same cycle.
    if (accept) begin
      width_d = width_cnt_q;
      code_d  = decode_width(width_cnt_q, CLO_W, CHI_W);
      lost_d  = 1'b0;
    end else if (lost_cnt_q == LOST_LIMIT) begin
      code_d = CODE_NEUTRAL;
      lost_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q     <= '0;
      width_cnt_q <= '0;
      lost_cnt_q  <= '0;
      width_q     <= '0;
      code_q      <= CODE_NEUTRAL;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      lost_q      <= 1'b1;
    end else begin
      presc_q     <= presc_d;
      width_cnt_q <= width_cnt_d;
      lost_cnt_q  <= lost_cnt_d;
      width_q     <= width_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      lost_q      <= lost_d;
    end
  end

  assign width_us    = width_q;
  assign code        = code_q;
  assign pulse_valid = valid_q;
  assign pulse_err   = err_q;
  assign signal_lost = lost_q;

endmodule

// File: tb/tb_rc_pulse_decoder.sv
// Self-checking bench for rc_pulse_decoder, run with scaled-down timing
// parameters (4 clocks per us, all widths divided by ten) to keep runs short.
module tb_rc_pulse_decoder;

  localparam int TICKS = 4;
  localparam int MINU  = 90;
  localparam int MAXU  = 210;
  localparam int CLO   = 140;
  localparam int CHI   = 160;
  localparam int TMO   = 2500;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pulse_in = 1'b0;
  logic [11:0] width_us;
  logic [1:0]  code;
  logic        pulse_valid;
  logic        pulse_err;
  logic        signal_lost;

  rc_pulse_decoder #(
    .TICKS_PER_US (TICKS),
    .MIN_US       (MINU),
    .MAX_US       (MAXU),
    .CENTER_LO_US (CLO),
    .CENTER_HI_US (CHI),
    .TIMEOUT_US   (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pulse_in    (pulse_in),
    .width_us    (width_us),
    .code        (code),
    .pulse_valid (pulse_valid),
    .pulse_err   (pulse_err),
    .signal_lost (signal_lost)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // One expected decoder outcome: at clock edge 'at' either an accepted
  // pulse (width/code update) or a rejection strobe.
  typedef struct {
    int         at;
    bit         acc;
    int         w;
    logic [1:0] c;
  } ev_t;

  ev_t        evq[$];
  int         mWidth      = 0;
  logic [1:0] mCode       = 2'b00;
  bit         mHaveAccept = 1'b0;
  int         mAcceptCyc  = 0;
  int         mRises      = 0;

  int edgeWidths[10] = '{89, 90, 139, 140, 141, 159, 160, 161, 210, 211};

  function automatic logic [1:0] expectCode(input int w);
    if (w < CLO) return 2'b01;
    if (w > CHI) return 2'b10;
    return 2'b00;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Drives one pulse of widthUs microseconds plus a sub-microsecond jitter,
  // then holds the line low for gapUs, queuing the outcome the rules predict.
  task automatic applyStimulus(input int widthUs, input int gapUs);
    int  jit;
    int  hi;
    int  rEdge;
    ev_t e;
    jit = $urandom_range(1, 3);
    hi  = widthUs * TICKS + jit;
    @(negedge clk);
    pulse_in = 1'b1;
    rEdge = cyc + 1;
    if (mHaveAccept) mRises++;
    e.w = widthUs;
    e.c = expectCode(widthUs);
    if (widthUs > MAXU) begin
      e.acc = 1'b0;
      e.at  = rEdge + 2 + (MAXU + 1) * TICKS;
    end else begin
      e.acc = (widthUs >= MINU);
      e.at  = rEdge + hi + 2;
    end
    evq.push_back(e);
    repeat (hi) @(negedge clk);
    pulse_in = 1'b0;
    repeat (gapUs * TICKS) @(negedge clk);
  endtask

  // Starts a pulse, resets the design partway through, and lets the pulse
  // finish; the truncated pulse must leave no trace.
  task automatic resetMidPulse(input int widthUs, input int cutUs, input int gapUs);
    @(negedge clk);
    pulse_in = 1'b1;
    repeat (cutUs * TICKS) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midrst_width", width_us, 0);
    checkOutput("midrst_code", code, 0);
    checkOutput("midrst_lost", signal_lost, 1);
    rst = 1'b0;
    repeat ((widthUs - cutUs) * TICKS) @(negedge clk);
    pulse_in = 1'b0;
    repeat (gapUs * TICKS) @(negedge clk);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : compare
    bit  expValid;
    bit  expErr;
    int  age;
    ev_t e;
    #1;
    if (rst) begin
      evq.delete();
      mWidth      = 0;
      mCode       = 2'b00;
      mHaveAccept = 1'b0;
      mRises      = 0;
      checkOutput("rst_width", width_us, 0);
      checkOutput("rst_code", code, 0);
      checkOutput("rst_valid", pulse_valid, 0);
      checkOutput("rst_err", pulse_err, 0);
      checkOutput("rst_lost", signal_lost, 1);
    end else begin
      expValid = 1'b0;
      expErr   = 1'b0;
      if (evq.size() > 0 && evq[0].at == cyc) begin
        e = evq.pop_front();
        if (e.acc) begin
          expValid    = 1'b1;
          mWidth      = e.w;
          mCode       = e.c;
          mHaveAccept = 1'b1;
          mAcceptCyc  = cyc;
          mRises      = 0;
        end else begin
          expErr = 1'b1;
        end
      end
      checkOutput("pulse_valid", pulse_valid, int'(expValid));
      checkOutput("pulse_err", pulse_err, int'(expErr));
      checkOutput("width_us", width_us, mWidth);
      if (mHaveAccept) begin
        age = cyc - mAcceptCyc;
        if (age < TMO * TICKS - TICKS) begin
          checkOutput("signal_lost", signal_lost, 0);
          checkOutput("code", code, int'(mCode));
        end else if (age > TMO * TICKS + 2 + mRises * TICKS) begin
          mHaveAccept = 1'b0;
          mCode       = 2'b00;
          checkOutput("timeout_lost", signal_lost, 1);
          checkOutput("timeout_code", code, 0);
        end
      end else begin
        checkOutput("signal_lost", signal_lost, 1);
        checkOutput("code", code, int'(mCode));
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pulse_in = 1'b0;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("init_width", width_us, 0);
    checkOutput("init_code", code, 0);
    checkOutput("init_lost", signal_lost, 1);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    applyStimulus(150, 20);
    checkOutput("p150_width", width_us, 150);
    checkOutput("p150_code", code, 0);
    checkOutput("p150_lost", signal_lost, 0);

    applyStimulus(100, 20);
    checkOutput("p100_width", width_us, 100);
    checkOutput("p100_code", code, 1);
    applyStimulus(200, 20);
    checkOutput("p200_width", width_us, 200);
    checkOutput("p200_code", code, 2);

    applyStimulus(85, 20);
    checkOutput("p85_width", width_us, 200);
    checkOutput("p85_code", code, 2);
    applyStimulus(90, 20);
    checkOutput("p90_width", width_us, 90);
    checkOutput("p90_code", code, 1);

    applyStimulus(300, 20);
    checkOutput("overrun_width", width_us, 90);
    applyStimulus(120, 20);
    checkOutput("p120_width", width_us, 120);

    applyStimulus(140, 20);
    checkOutput("p140_code", code, 0);
    applyStimulus(160, 20);
    checkOutput("p160_code", code, 0);
    applyStimulus(210, 20);
    checkOutput("p210_width", width_us, 210);
    checkOutput("p210_code", code, 2);

    applyStimulus(180, TMO + 100);
    checkOutput("lost_lost", signal_lost, 1);
    checkOutput("lost_code", code, 0);
    checkOutput("lost_width", width_us, 180);
    applyStimulus(150, 20);
    checkOutput("relock_lost", signal_lost, 0);
    checkOutput("relock_width", width_us, 150);

    resetMidPulse(160, 70, 20);
    checkOutput("after_rst_width", width_us, 0);
    checkOutput("after_rst_lost", signal_lost, 1);
    applyStimulus(150, 20);
    checkOutput("post_rst_width", width_us, 150);
    checkOutput("post_rst_code", code, 0);

    for (int i = 0; i < 20; i++) begin
      int w;
      if ($urandom_range(0, 1) == 1) begin
        w = edgeWidths[$urandom_range(0, 9)];
      end else begin
        w = $urandom_range(50, 260);
      end
      applyStimulus(w, $urandom_range(10, 150));
    end

    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
